// File: rtl/operand_pair_loader.sv
// Collects operand A then operand B from one narrow valid/ready bus and
// presents them as a registered pair with out_valid; counts delivered pairs.
module operand_pair_loader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic               out_valid_q, busy_q;
  logic [CNT_W-1:0]   pair_cnt_q;

  logic               accept;
  logic               deliver;
  logic               load_a;
  logic               load_b;
  logic               count_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over every handshake
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = HAVE_A;
        HAVE_A:  if (accept) state_d = FULL;
        FULL: begin
          if (deliver && accept) state_d = HAVE_A;
          else if (deliver)      state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output / handshake decode
  always_comb begin
    in_ready = 1'b1;
    if (state_q == FULL) begin
      in_ready = out_ready;
    end
    accept   = in_valid & in_ready;
    deliver  = out_valid_q & out_ready;
    load_a   = 1'b0;
    load_b   = 1'b0;
    count_en = deliver & ~flush;
    if (!flush && accept) begin
      load_a = (state_q == EMPTY) || (state_q == FULL);
      load_b = (state_q == HAVE_A);
    end
  end

  // Operand registers keep stale contents across a flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      if (load_a) op_a_q <= in_data;
      if (load_b) op_b_q <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= (state_d == FULL);
      busy_q      <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_cnt_q <= '0;
    end else if (count_en) begin
      pair_cnt_q <= pair_cnt_q + CNT_W'(1);
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign pair_cnt  = pair_cnt_q;

endmodule
